// File: rtl/wb_regfile.sv
// Writeback consumer: formats the writeback value, commits it to a 32x32 register file,
// and tracks the last commit and the retired-instruction count.
// Optional REGFILE_BYPASS_EN: same-cycle write-to-read forwarding on both read ports.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wb_sel,
    input  logic             regWEn,
    input  logic [XLEN-1:0]  pc_4_wb,
    input  logic [XLEN-1:0]  alu_out_wb,
    input  logic [XLEN-1:0]  dmem_out_wb,
    input  logic [31:0]      instr_wb,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [XLEN-1:0]  wb_data,
    output logic [4:0]       last_rd,
    output logic [XLEN-1:0]  last_wdata,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [4:0]       last_rd_q, last_rd_d;
    logic [XLEN-1:0]  last_wdata_q, last_wdata_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      opcode;
    logic [1:0]      off;
    logic            unusedInstrBits;
    logic [7:0]      loadByte;
    logic [15:0]     loadHalf;
    logic [XLEN-1:0] loadData;
    logic [XLEN-1:0] wbValue;
    logic            we;
    logic            retire;

    assign rd              = instr_wb[11:7];
    assign funct3          = instr_wb[14:12];
    assign opcode          = instr_wb[6:0];
    assign off             = alu_out_wb[1:0];
    assign unusedInstrBits = ^instr_wb[31:15];

    // Halfword selection uses only off[1]; misaligned halfword offsets round down.
    always_comb begin
        loadByte = dmem_out_wb[{off, 3'b000} +: 8];
        loadHalf = dmem_out_wb[{off[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
            3'b100:  loadData = {{(XLEN-8){1'b0}}, loadByte};
            3'b001:  loadData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
            3'b101:  loadData = {{(XLEN-16){1'b0}}, loadHalf};
            default: loadData = dmem_out_wb;
        endcase
    end

    always_comb begin
        case (wb_sel)
            2'b00:   wbValue = loadData;
            2'b01:   wbValue = alu_out_wb;
            2'b10:   wbValue = pc_4_wb;
            default: wbValue = '0;
        endcase
    end

    assign wb_data = wbValue;
    assign we = regWEn && (wb_sel != 2'b11) && (rd != 5'd0) &&
                (opcode != OP_BRANCH) && (opcode != OP_STORE);

    always_comb begin
        case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: retire = 1'b1;
            default:                                        retire = 1'b0;
        endcase
    end

    always_comb begin
        last_rd_d    = last_rd_q;
        last_wdata_d = last_wdata_q;
        instret_d    = instret_q + {{(CNT_W-1){1'b0}}, retire};
        if (we) begin
            last_rd_d    = rd;
            last_wdata_d = wbValue;
        end
    end

    // Reset wins over a concurrent commit or retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            last_rd_q    <= '0;
            last_wdata_q <= '0;
            instret_q    <= '0;
        end else begin
            if (we) regs_q[rd] <= wbValue;
            last_rd_q    <= last_rd_d;
            last_wdata_q <= last_wdata_d;
            instret_q    <= instret_d;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (we && (rs1_addr == rd)) rs1_data = wbValue;
        if (we && (rs2_addr == rd)) rs2_data = wbValue;
`endif
    end

    assign last_rd    = last_rd_q;
    assign last_wdata = last_wdata_q;
    assign instret    = instret_q;

endmodule
